affinex_point_fifo: RTL and testbench
=====================================

Name: affinex_point_fifo

Overview:
Input point buffer for the affine transform peripheral's batch (FIFO) mode. It sits between the TinyQV bus register decode and the transform engine.
- Bus writes to the FIFO X/Y input registers are assembled into signed (X,Y) point pairs and queued here.
- The transform engine pops one point per transform through a valid/ready handshake.
- Head data is presented first-word-fall-through, so the engine can start COMPUTE1 in the same cycle it pops.

Parameters:
DEPTH, 8, number of point entries; power of two, 2..32.
WIDTH, 16, bit width of each coordinate (signed two's complement).

Ports:
clk  in  1  peripheral clock (64 MHz nominal)
rst_n  in  1  asynchronous active-low reset
clear_i  in  1  synchronous flush: empties FIFO, clears staged X and flags
wr_x_i  in  1  one-cycle strobe: stage wdata_i as pending X
wr_y_i  in  1  one-cycle strobe: push {staged X, wdata_i} as one point
wdata_i  in  WIDTH  coordinate write data (bus data_in[WIDTH-1:0])
pt_valid_o  out  1  head point available (== !empty_o)
pt_ready_i  in  1  engine accepts head; pop occurs when pt_valid_o && pt_ready_i
pt_x_o  out  WIDTH  head X coordinate
pt_y_o  out  WIDTH  head Y coordinate
count_o  out  $clog2(DEPTH)+1  number of stored points, 0..DEPTH
full_o  out  1  count_o == DEPTH
empty_o  out  1  count_o == 0
x_pending_o  out  1  X staged, waiting for its Y
overflow_o  out  1  sticky: a push was dropped because the FIFO was full

Behaviour:
- Reset (rst_n low, asynchronous) drives the following values:
  - count_o=0, empty_o=1, full_o=0, pt_valid_o=0.
  - pt_x_o=0 and pt_y_o=0 (storage is reset).
  - x_pending_o=0, overflow_o=0, staged X=0, read/write pointers=0.
- Storage: DEPTH x (2*WIDTH) register array. Read and write pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
- X staging:
  - wr_x_i loads staged X <= wdata_i and sets x_pending_o=1.
  - A second wr_x_i before a Y overwrites staged X; no error is flagged.
- Push:
  - wr_y_i writes {staged X, wdata_i} at the write pointer, advances it, and clears x_pending_o.
  - wr_y_i without a pending X still pushes, using the retained staged X value.
  - wr_x_i and wr_y_i in the same cycle: X is staged first, so the pushed point is (wdata_i, wdata_i) and x_pending_o ends at 0.
- Pop: on pt_valid_o && pt_ready_i the read pointer advances. pt_x_o/pt_y_o always reflect the entry at the read pointer (combinational read, FWFT).
- Latency: a point pushed at edge N is visible with pt_valid_o=1 after edge N. There is no same-cycle bypass; an empty FIFO never presents valid.
- Full:
  - A push with no simultaneous pop is dropped: storage, pointers and count are unchanged, overflow_o <= 1.
  - A push with a simultaneous pop succeeds; count stays DEPTH and overflow is not set.
- Empty: pt_ready_i has no effect. Push plus ready in the same cycle performs only the push.
- Count arithmetic: count_o += push_ok, -= pop_ok. It never exceeds DEPTH and never underflows.
- clear_i:
  - Takes priority over every same-cycle push, pop and wr_x_i.
  - Resets pointers, count, x_pending_o, staged X and overflow_o.
  - Storage contents are left as-is.
- overflow_o stays set until clear_i or reset.
- Reset mid-operation: all state returns to reset values immediately; no partially staged point survives.

Optional Feature:
Macro AFFINEX_FIFO_WMARK_EN.
- Defined: adds ports wmark_i (in, $clog2(DEPTH)+1) and level_irq_o (out, 1).
  - level_irq_o is registered: 1 when count_o >= wmark_i and wmark_i != 0; otherwise 0.
  - It updates one cycle after the count change and resets to 0.
  - It feeds user_interrupt so firmware can refill in batches.
- Undefined: neither port exists and no watermark logic is synthesized.

Test Plan:
- Reset, then wr_x_i=0x0100, then wr_y_i=0xFF00 -> x_pending_o goes 1 then 0; next cycle pt_valid_o=1, pt_x_o=0x0100, pt_y_o=0xFF00, count_o=1.
- Push 8 distinct points (X=i, Y=-i), hold pt_ready_i=1 -> points pop in order 0..7; count_o returns to 0, empty_o=1, pointers wrap; a 9th push/pop pair again yields correct data.
- Fill 8 points, push a 9th (X=0x7FFF, Y=0x8000) with ready=0 -> overflow_o=1, count_o=8; the popped sequence excludes the 9th point.
- Full FIFO, push and pop in the same cycle -> count_o stays 8, overflow_o stays 0; the new point emerges last.
- Three points queued with x_pending_o=1 and overflow_o=1, assert clear_i together with wr_y_i -> next cycle count_o=0, empty_o=1, x_pending_o=0, overflow_o=0; no push happened.
- With AFFINEX_FIFO_WMARK_EN and wmark_i=4: push 4 points -> level_irq_o=1 one cycle after the 4th push; pop one -> level_irq_o=0 one cycle later.

Source files
------------

// File: rtl/affinex_point_fifo_if.sv
// Point-FIFO bus bundle: coordinate write strobes, engine valid/ready pop, status.
// Optional watermark signals exist only when AFFINEX_FIFO_WMARK_EN is defined.
interface affinex_point_fifo_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             clear_i;
    logic             wr_x_i;
    logic             wr_y_i;
    logic [WIDTH-1:0] wdata_i;
    logic             pt_valid_o;
    logic             pt_ready_i;
    logic [WIDTH-1:0] pt_x_o;
    logic [WIDTH-1:0] pt_y_o;
    logic [CW-1:0]    count_o;
    logic             full_o;
    logic             empty_o;
    logic             x_pending_o;
    logic             overflow_o;
`ifdef AFFINEX_FIFO_WMARK_EN
    logic [CW-1:0]    wmark_i;
    logic             level_irq_o;

    modport master (
        output clear_i, wr_x_i, wr_y_i, wdata_i, pt_ready_i, wmark_i,
        input  pt_valid_o, pt_x_o, pt_y_o, count_o, full_o, empty_o,
               x_pending_o, overflow_o, level_irq_o
    );
    modport slave (
        input  clear_i, wr_x_i, wr_y_i, wdata_i, pt_ready_i, wmark_i,
        output pt_valid_o, pt_x_o, pt_y_o, count_o, full_o, empty_o,
               x_pending_o, overflow_o, level_irq_o
    );
`else
    modport master (
        output clear_i, wr_x_i, wr_y_i, wdata_i, pt_ready_i,
        input  pt_valid_o, pt_x_o, pt_y_o, count_o, full_o, empty_o,
               x_pending_o, overflow_o
    );
    modport slave (
        input  clear_i, wr_x_i, wr_y_i, wdata_i, pt_ready_i,
        output pt_valid_o, pt_x_o, pt_y_o, count_o, full_o, empty_o,
               x_pending_o, overflow_o
    );
`endif
endinterface

// File: rtl/affinex_point_fifo.sv
// Input point FIFO for the affine transform batch mode: stages X, pushes (X,Y)
// on a Y write, presents the head first-word-fall-through to the engine.
// Optional registered watermark interrupt: define AFFINEX_FIFO_WMARK_EN.
module affinex_point_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    affinex_point_fifo_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] stx_q, stx_d;
    logic             xpend_q, xpend_d;
    logic             ovf_q, ovf_d;
    logic             push_ok, pop_ok;
    logic [WIDTH-1:0] x_eff;
    logic             is_empty, is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    // Next-state: clear wins over everything; a pop frees room for a same-cycle push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        stx_d    = stx_q;
        xpend_d  = xpend_q;
        ovf_d    = ovf_q;
        pop_ok   = bus.pt_ready_i && !is_empty;
        push_ok  = bus.wr_y_i && (!is_full || pop_ok);
        x_eff    = bus.wr_x_i ? bus.wdata_i : stx_q;
        if (bus.clear_i) begin
            pop_ok   = 1'b0;
            push_ok  = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            stx_d    = '0;
            xpend_d  = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            if (bus.wr_x_i) begin
                stx_d   = bus.wdata_i;
                xpend_d = 1'b1;
            end
            if (bus.wr_y_i) begin
                xpend_d = 1'b0;
                if (!push_ok) ovf_d = 1'b1;
            end
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stx_q    <= '0;
            xpend_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stx_q    <= stx_d;
            xpend_q  <= xpend_d;
            ovf_q    <= ovf_d;
        end
    end

    // Point storage; reset so the head reads zero out of reset, untouched by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= {x_eff, bus.wdata_i};
        end
    end

    assign bus.pt_valid_o  = !is_empty;
    assign bus.pt_x_o      = mem_q[rd_ptr_q][PW-1:WIDTH];
    assign bus.pt_y_o      = mem_q[rd_ptr_q][WIDTH-1:0];
    assign bus.count_o     = count_q;
    assign bus.full_o      = is_full;
    assign bus.empty_o     = is_empty;
    assign bus.x_pending_o = xpend_q;
    assign bus.overflow_o  = ovf_q;

`ifdef AFFINEX_FIFO_WMARK_EN
    logic level_irq_q;

    // Watermark level interrupt, one cycle behind the stored count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) level_irq_q <= 1'b0;
        else        level_irq_q <= (bus.wmark_i != '0) && (count_q >= bus.wmark_i);
    end

    assign bus.level_irq_o = level_irq_q;
`endif
endmodule

// File: tb/tb_affinex_point_fifo.sv
// Bench for affinex_point_fifo: directed scenarios plus randomized traffic
// checked against a queue-based point model.
module tb_affinex_point_fifo;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned CW    = 4;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
    } pt_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    affinex_point_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) ifc ();
    affinex_point_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc)
    );

    pt_t         mq[$];
    logic [15:0] m_stx;
    bit          m_pend, m_ovf, m_irq;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic model_reset();
        mq.delete();
        m_stx  = '0;
        m_pend = 1'b0;
        m_ovf  = 1'b0;
        m_irq  = 1'b0;
    endtask

    // Advance the model with the currently driven inputs, then clock the DUT.
    task automatic step();
        bit          pop;
        pt_t         p;
        logic [15:0] xv;
`ifdef AFFINEX_FIFO_WMARK_EN
        m_irq = (ifc.wmark_i != 0) && (mq.size() >= int'(ifc.wmark_i));
`endif
        if (ifc.clear_i) begin
            mq.delete();
            m_stx = '0; m_pend = 1'b0; m_ovf = 1'b0;
        end else begin
            pop = ifc.pt_ready_i && (mq.size() > 0);
            xv  = ifc.wr_x_i ? ifc.wdata_i : m_stx;
            if (ifc.wr_x_i) begin m_stx = ifc.wdata_i; m_pend = 1'b1; end
            if (pop) p = mq.pop_front();
            if (ifc.wr_y_i) begin
                m_pend = 1'b0;
                if (mq.size() < int'(DEPTH)) mq.push_back('{x: xv, y: ifc.wdata_i});
                else m_ovf = 1'b1;
            end
        end
        @(posedge clk); #1;
        ifc.wr_x_i = 1'b0; ifc.wr_y_i = 1'b0; ifc.clear_i = 1'b0;
    endtask

    task automatic push(input logic [15:0] x, input logic [15:0] y);
        ifc.wr_x_i = 1'b1; ifc.wdata_i = x; step();
        ifc.wr_y_i = 1'b1; ifc.wdata_i = y; step();
    endtask

    task automatic do_clear();
        ifc.clear_i = 1'b1; step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; model_reset();
        #3;
        n_total++;
        if ({ifc.count_o, ifc.empty_o, ifc.full_o, ifc.pt_valid_o, ifc.x_pending_o, ifc.overflow_o} !== {4'd0, 5'b10000})
            $display("FAIL reset_flags: got cnt=%0d e=%b f=%b v=%b p=%b o=%b, need cnt=0 e=1 f=0 v=0 p=0 o=0",
                     ifc.count_o, ifc.empty_o, ifc.full_o, ifc.pt_valid_o, ifc.x_pending_o, ifc.overflow_o);
        else n_pass++;
        n_total++;
        if ({ifc.pt_x_o, ifc.pt_y_o} !== 32'h0)
            $display("FAIL reset_data: got %h/%h need 0000/0000", ifc.pt_x_o, ifc.pt_y_o);
        else n_pass++;
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_basic();
        ifc.wr_x_i = 1'b1; ifc.wdata_i = 16'h0100; step();
        n_total++;
        if (ifc.x_pending_o !== 1'b1 || ifc.pt_valid_o !== 1'b0)
            $display("FAIL basic_stage: got pend=%b valid=%b need 1/0", ifc.x_pending_o, ifc.pt_valid_o);
        else n_pass++;
        ifc.wr_y_i = 1'b1; ifc.wdata_i = 16'hFF00; step();
        n_total++;
        if ({ifc.x_pending_o, ifc.pt_valid_o, ifc.count_o, ifc.pt_x_o, ifc.pt_y_o} !== {1'b0, 1'b1, 4'd1, 16'h0100, 16'hFF00})
            $display("FAIL basic_push: got p=%b v=%b cnt=%0d %h/%h need 0 1 1 0100/ff00",
                     ifc.x_pending_o, ifc.pt_valid_o, ifc.count_o, ifc.pt_x_o, ifc.pt_y_o);
        else n_pass++;
        ifc.pt_ready_i = 1'b1; step(); ifc.pt_ready_i = 1'b0;
        n_total++;
        if (ifc.empty_o !== 1'b1 || ifc.count_o !== 4'd0)
            $display("FAIL basic_pop: got empty=%b cnt=%0d need 1/0", ifc.empty_o, ifc.count_o);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int bad = 0;
        ifc.pt_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(16'(i), 16'(-i));
            if (ifc.pt_x_o !== 16'(i) || ifc.pt_y_o !== 16'(-i) || ifc.count_o !== 4'd1) bad++;
        end
        step();
        n_total++;
        if (bad != 0) $display("FAIL wrap_order: got %0d wrong heads need 0", bad);
        else n_pass++;
        n_total++;
        if (ifc.count_o !== 4'd0 || ifc.empty_o !== 1'b1)
            $display("FAIL wrap_drain: got cnt=%0d empty=%b need 0/1", ifc.count_o, ifc.empty_o);
        else n_pass++;
        push(16'h1234, 16'h4321);
        n_total++;
        if (ifc.pt_x_o !== 16'h1234 || ifc.pt_y_o !== 16'h4321)
            $display("FAIL wrap_ninth: got %h/%h need 1234/4321", ifc.pt_x_o, ifc.pt_y_o);
        else n_pass++;
        step(); ifc.pt_ready_i = 1'b0;
    endtask

    task automatic test_overflow();
        int bad = 0;
        ifc.pt_ready_i = 1'b0; do_clear();
        for (int i = 0; i < 8; i++) push(16'(i + 16), 16'(i + 32));
        n_total++;
        if (ifc.full_o !== 1'b1 || ifc.overflow_o !== 1'b0)
            $display("FAIL ovf_full: got full=%b ovf=%b need 1/0", ifc.full_o, ifc.overflow_o);
        else n_pass++;
        push(16'h7FFF, 16'h8000);
        n_total++;
        if (ifc.overflow_o !== 1'b1 || ifc.count_o !== 4'd8)
            $display("FAIL ovf_drop: got ovf=%b cnt=%0d need 1/8", ifc.overflow_o, ifc.count_o);
        else n_pass++;
        ifc.pt_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (ifc.pt_x_o !== 16'(i + 16) || ifc.pt_y_o !== 16'(i + 32)) bad++;
            step();
        end
        ifc.pt_ready_i = 1'b0;
        n_total++;
        if (bad != 0 || ifc.count_o !== 4'd0 || ifc.overflow_o !== 1'b1)
            $display("FAIL ovf_drain: got bad=%0d cnt=%0d ovf=%b need 0/0/1", bad, ifc.count_o, ifc.overflow_o);
        else n_pass++;
    endtask

    task automatic test_full_push_pop();
        int bad = 0;
        ifc.pt_ready_i = 1'b0; do_clear();
        for (int i = 0; i < 8; i++) push(16'(i + 1), 16'(i + 100));
        ifc.wr_x_i = 1'b1; ifc.wdata_i = 16'hAAAA; step();
        ifc.wr_y_i = 1'b1; ifc.wdata_i = 16'h5555; ifc.pt_ready_i = 1'b1; step();
        ifc.pt_ready_i = 1'b0;
        n_total++;
        if (ifc.count_o !== 4'd8 || ifc.overflow_o !== 1'b0 || ifc.pt_x_o !== 16'd2)
            $display("FAIL fpp_state: got cnt=%0d ovf=%b head=%h need 8/0/0002", ifc.count_o, ifc.overflow_o, ifc.pt_x_o);
        else n_pass++;
        ifc.pt_ready_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (ifc.pt_x_o !== 16'(i + 2) || ifc.pt_y_o !== 16'(i + 101)) bad++;
            step();
        end
        n_total++;
        if (bad != 0 || ifc.pt_x_o !== 16'hAAAA || ifc.pt_y_o !== 16'h5555)
            $display("FAIL fpp_last: got bad=%0d last=%h/%h need 0 aaaa/5555", bad, ifc.pt_x_o, ifc.pt_y_o);
        else n_pass++;
        step(); ifc.pt_ready_i = 1'b0;
    endtask

    task automatic test_clear();
        ifc.pt_ready_i = 1'b0; do_clear();
        for (int i = 0; i < 8; i++) push(16'(i), 16'(i));
        ifc.wr_y_i = 1'b1; ifc.wdata_i = 16'h0001; step();
        ifc.pt_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) step();
        ifc.pt_ready_i = 1'b0;
        ifc.wr_x_i = 1'b1; ifc.wdata_i = 16'h0777; step();
        n_total++;
        if (ifc.count_o !== 4'd3 || ifc.x_pending_o !== 1'b1 || ifc.overflow_o !== 1'b1)
            $display("FAIL clr_setup: got cnt=%0d p=%b o=%b need 3/1/1", ifc.count_o, ifc.x_pending_o, ifc.overflow_o);
        else n_pass++;
        ifc.clear_i = 1'b1; ifc.wr_y_i = 1'b1; ifc.wdata_i = 16'h0999; step();
        n_total++;
        if ({ifc.count_o, ifc.empty_o, ifc.pt_valid_o, ifc.x_pending_o, ifc.overflow_o} !== {4'd0, 4'b1000})
            $display("FAIL clr_state: got cnt=%0d e=%b v=%b p=%b o=%b need 0 1 0 0 0",
                     ifc.count_o, ifc.empty_o, ifc.pt_valid_o, ifc.x_pending_o, ifc.overflow_o);
        else n_pass++;
        ifc.wr_y_i = 1'b1; ifc.wdata_i = 16'h0042; step();
        n_total++;
        if (ifc.pt_x_o !== 16'h0000 || ifc.pt_y_o !== 16'h0042 || ifc.count_o !== 4'd1)
            $display("FAIL clr_stagedx: got %h/%h cnt=%0d need 0000/0042 1", ifc.pt_x_o, ifc.pt_y_o, ifc.count_o);
        else n_pass++;
        ifc.wr_x_i = 1'b1; ifc.wr_y_i = 1'b1; ifc.wdata_i = 16'h0ABC; step();
        ifc.pt_ready_i = 1'b1; step(); ifc.pt_ready_i = 1'b0;
        n_total++;
        if (ifc.pt_x_o !== 16'h0ABC || ifc.pt_y_o !== 16'h0ABC || ifc.x_pending_o !== 1'b0)
            $display("FAIL xy_same: got %h/%h p=%b need 0abc/0abc 0", ifc.pt_x_o, ifc.pt_y_o, ifc.x_pending_o);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        do_clear();
        push(16'h0011, 16'h0022);
        ifc.wr_x_i = 1'b1; ifc.wdata_i = 16'h0033; step();
        #2 rst_n = 1'b0; model_reset();
        #1;
        n_total++;
        if (ifc.count_o !== 4'd0 || ifc.x_pending_o !== 1'b0 || ifc.pt_x_o !== 16'h0)
            $display("FAIL rst_mid: got cnt=%0d p=%b x=%h need 0/0/0000", ifc.count_o, ifc.x_pending_o, ifc.pt_x_o);
        else n_pass++;
        @(posedge clk); #1; rst_n = 1'b1;
        ifc.wr_y_i = 1'b1; ifc.wdata_i = 16'h0005; step();
        n_total++;
        if (ifc.pt_x_o !== 16'h0000 || ifc.pt_y_o !== 16'h0005)
            $display("FAIL rst_stagedx: got %h/%h need 0000/0005", ifc.pt_x_o, ifc.pt_y_o);
        else n_pass++;
    endtask

`ifdef AFFINEX_FIFO_WMARK_EN
    task automatic test_wmark();
        ifc.pt_ready_i = 1'b0; do_clear(); step();
        ifc.wmark_i = 4'd4;
        for (int i = 0; i < 4; i++) push(16'(i), 16'(i));
        n_total++;
        if (ifc.level_irq_o !== 1'b0) $display("FAIL wm_early: got %b need 0", ifc.level_irq_o);
        else n_pass++;
        step();
        n_total++;
        if (ifc.level_irq_o !== 1'b1) $display("FAIL wm_set: got %b need 1", ifc.level_irq_o);
        else n_pass++;
        ifc.pt_ready_i = 1'b1; step(); ifc.pt_ready_i = 1'b0;
        step();
        n_total++;
        if (ifc.level_irq_o !== 1'b0) $display("FAIL wm_drop: got %b need 0", ifc.level_irq_o);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        int bad = 0;
        do_clear();
        for (int c = 0; c < 400; c++) begin
            ifc.clear_i    = ($urandom_range(0, 49) == 0);
            ifc.wr_x_i     = ($urandom_range(0, 2) == 0);
            ifc.wr_y_i     = ($urandom_range(0, 2) == 0);
            ifc.pt_ready_i = ($urandom_range(0, 1) == 0);
            ifc.wdata_i    = 16'($urandom);
`ifdef AFFINEX_FIFO_WMARK_EN
            if ($urandom_range(0, 31) == 0) ifc.wmark_i = 4'($urandom_range(0, 8));
`endif
            step();
            n_total++;
            if (ifc.count_o !== 4'(mq.size()) || ifc.pt_valid_o !== (mq.size() > 0) ||
                ifc.x_pending_o !== m_pend || ifc.overflow_o !== m_ovf ||
                ifc.full_o !== (mq.size() == int'(DEPTH))) begin
                if (bad < 5)
                    $display("FAIL rnd_state c=%0d: got cnt=%0d p=%b o=%b need cnt=%0d p=%b o=%b",
                             c, ifc.count_o, ifc.x_pending_o, ifc.overflow_o, mq.size(), m_pend, m_ovf);
                bad++;
            end else n_pass++;
            if (mq.size() > 0) begin
                n_total++;
                if ({ifc.pt_x_o, ifc.pt_y_o} !== {mq[0].x, mq[0].y}) begin
                    if (bad < 5)
                        $display("FAIL rnd_head c=%0d: got %h/%h need %h/%h", c, ifc.pt_x_o, ifc.pt_y_o, mq[0].x, mq[0].y);
                    bad++;
                end else n_pass++;
            end
`ifdef AFFINEX_FIFO_WMARK_EN
            n_total++;
            if (ifc.level_irq_o !== m_irq) begin
                if (bad < 5) $display("FAIL rnd_irq c=%0d: got %b need %b", c, ifc.level_irq_o, m_irq);
                bad++;
            end else n_pass++;
`endif
        end
        ifc.pt_ready_i = 1'b0;
    endtask

    initial begin
        ifc.clear_i = 1'b0; ifc.wr_x_i = 1'b0; ifc.wr_y_i = 1'b0;
        ifc.wdata_i = '0;   ifc.pt_ready_i = 1'b0;
`ifdef AFFINEX_FIFO_WMARK_EN
        ifc.wmark_i = '0;
`endif
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_wrap();
        test_overflow();
        test_full_push_pop();
        test_clear();
        test_reset_midop();
`ifdef AFFINEX_FIFO_WMARK_EN
        test_wmark();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
